// File: rtl/delay_ctrl_pkg.sv
// Shared types and helpers for the programmable delay line.
package delay_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  function automatic logic delay_ok(
    input logic [31:0] d,
    input int unsigned max_n
  );
    return (d != 32'd0) && (d <= max_n);
  endfunction

endpackage

// File: rtl/delay_ram.sv
// Simple dual-port sample buffer, synchronous read, read-before-write.
module delay_ram #(
  parameter int unsigned BITSIZE = 8,
  parameter int unsigned MAX_N   = 16,
  parameter int unsigned PTR_W   = $clog2(MAX_N)
) (
  input  logic               clk,
  input  logic               we,
  input  logic               re,
  input  logic [PTR_W-1:0]   addr,
  input  logic [BITSIZE-1:0] wdata,
  output logic [BITSIZE-1:0] rdata
);

  logic [BITSIZE-1:0] mem [MAX_N];

  // Same-edge read sees the old word at addr.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[addr];
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/delay_line_ctrl.sv
// Runtime-programmable sample delay built on a circular RAM buffer.
module delay_line_ctrl
  import delay_ctrl_pkg::*;
#(
  parameter int unsigned BITSIZE = 8,
  parameter int unsigned MAX_N   = 16,
  parameter int unsigned PTR_W   = $clog2(MAX_N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [PTR_W:0]     cfg_delay,
  input  logic               in_valid,
  input  logic [BITSIZE-1:0] in_data,
  output logic               out_valid,
  output logic [BITSIZE-1:0] out_data,
  output logic               busy,
  output logic               cfg_err,
  output logic [PTR_W:0]     cur_delay
);

  state_t             state, state_nx;
  logic [PTR_W-1:0]   wr_ptr, wr_ptr_nx;
  logic [PTR_W-1:0]   fill_cnt, fill_cnt_nx;
  logic [PTR_W:0]     cur_delay_nx;
  logic [PTR_W:0]     dm1;
  logic               cfg_err_nx;
  logic               cfg_ok;
  logic               accept;
  logic               rd_en;
  logic               sel_ram;
  logic [BITSIZE-1:0] ram_q;

  assign cfg_ok = delay_ok(32'(cfg_delay), MAX_N);
  assign dm1    = cur_delay - 1'b1;
  assign accept = in_valid && !cfg_load && (state != IDLE);
  assign rd_en  = accept && (state == RUN);
  assign busy   = (state == FILL);

  always_comb begin
    state_nx     = state;
    wr_ptr_nx    = wr_ptr;
    fill_cnt_nx  = fill_cnt;
    cur_delay_nx = cur_delay;
    cfg_err_nx   = cfg_err;
    if (cfg_load) begin
      if (cfg_ok) begin
        state_nx     = FILL;
        wr_ptr_nx    = '0;
        fill_cnt_nx  = '0;
        cur_delay_nx = cfg_delay;
      end else begin
        cfg_err_nx = 1'b1;
      end
    end else if (accept) begin
      // Buffer length tracks D, so wrap at D-1 rather than MAX_N-1.
      if ({1'b0, wr_ptr} == dm1) wr_ptr_nx = '0;
      else                       wr_ptr_nx = wr_ptr + 1'b1;
      if (state == FILL) begin
        fill_cnt_nx = fill_cnt + 1'b1;
        if ({1'b0, fill_cnt} == dm1) state_nx = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      fill_cnt  <= '0;
      cur_delay <= '0;
      cfg_err   <= 1'b0;
      out_valid <= 1'b0;
      sel_ram   <= 1'b0;
    end else begin
      state     <= state_nx;
      wr_ptr    <= wr_ptr_nx;
      fill_cnt  <= fill_cnt_nx;
      cur_delay <= cur_delay_nx;
      cfg_err   <= cfg_err_nx;
      out_valid <= accept;
      sel_ram   <= rd_en;
    end
  end

  // Fill-phase outputs are forced to zero, like a cleared shift register.
  assign out_data = sel_ram ? ram_q : '0;

  delay_ram #(
    .BITSIZE(BITSIZE),
    .MAX_N  (MAX_N),
    .PTR_W  (PTR_W)
  ) u_ram (
    .clk  (clk),
    .we   (accept),
    .re   (rd_en),
    .addr (wr_ptr),
    .wdata(in_data),
    .rdata(ram_q)
  );

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Scoreboard bench for delay_line_ctrl against a sample-history model.
module tb_delay_line_ctrl;

  localparam int BITSIZE = 8;
  localparam int MAX_N   = 16;
  localparam int PTR_W   = $clog2(MAX_N);

  logic               clk = 1'b0;
  logic               reset;
  logic               cfg_load;
  logic [PTR_W:0]     cfg_delay;
  logic               in_valid;
  logic [BITSIZE-1:0] in_data;
  logic               out_valid;
  logic [BITSIZE-1:0] out_data;
  logic               busy;
  logic               cfg_err;
  logic [PTR_W:0]     cur_delay;

  int compared   = 0;
  int mismatched = 0;

  logic [BITSIZE-1:0] exp_q [$];

  bit                 m_active;
  int                 m_d;
  bit                 m_err;
  logic [BITSIZE-1:0] m_hist [$];

  always #5 clk = ~clk;

  delay_line_ctrl #(
    .BITSIZE(BITSIZE),
    .MAX_N  (MAX_N)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_load (cfg_load),
    .cfg_delay(cfg_delay),
    .in_valid (in_valid),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_data (out_data),
    .busy     (busy),
    .cfg_err  (cfg_err),
    .cur_delay(cur_delay)
  );

  task automatic check(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops one expectation per output strobe, 1 clk after its input.
  always @(posedge clk) begin
    #1;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        check("out_data", int'(out_data), int'(exp_q.pop_front()));
      end
    end else if (exp_q.size() != 0) begin
      check("missing_out_valid", 0, 1);
      exp_q.delete();
    end
  end

  function automatic bit legal(input int d);
    return d >= 1 && d <= MAX_N;
  endfunction

  // One clock of stimulus; status is checked against the model first.
  task automatic step(input bit r, input bit ld, input int d,
                      input bit v, input int x);
    int n;
    @(negedge clk);
    check("busy", int'(busy), int'(m_active && m_hist.size() < m_d));
    check("cur_delay", int'(cur_delay), m_d);
    check("cfg_err", int'(cfg_err), int'(m_err));
    reset     = r;
    cfg_load  = ld;
    cfg_delay = (PTR_W+1)'(d);
    in_valid  = v;
    in_data   = BITSIZE'(x);
    if (r) begin
      m_active = 0;
      m_d      = 0;
      m_err    = 0;
      m_hist.delete();
    end else if (ld) begin
      if (legal(d)) begin
        m_active = 1;
        m_d      = d;
        m_hist.delete();
      end else begin
        m_err = 1;
      end
    end else if (v && m_active) begin
      n = m_hist.size();
      exp_q.push_back(n < m_d ? '0 : m_hist[n - m_d]);
      m_hist.push_back(BITSIZE'(x));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic stream(input int first, input int cnt);
    for (int i = 0; i < cnt; i++) step(0, 0, 0, 1, first + i);
  endtask

  initial begin
    reset     = 1'b1;
    cfg_load  = 1'b0;
    cfg_delay = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 7);
    @(negedge clk);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data", int'(out_data), 0);

    step(0, 1, 4, 0, 0);
    stream(1, 12);
    idle(2);

    step(0, 1, 1, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 0, 1, 10 * i);
      idle(2);
    end

    step(0, 1, 16, 0, 0);
    stream(1, 40);
    idle(1);

    step(0, 1, 4, 0, 0);
    stream(1, 10);
    step(0, 1, 2, 1, 99);
    stream(100, 8);
    idle(1);

    step(0, 1, 3, 0, 0);
    stream(50, 6);
    step(0, 1, 0, 0, 0);
    stream(56, 4);
    step(0, 1, 17, 0, 0);
    stream(60, 6);

    step(1, 0, 0, 1, 55);
    stream(70, 4);
    step(0, 1, 2, 0, 0);
    stream(80, 6);
    idle(1);

    for (int i = 0; i < 800; i++) begin
      int p = $urandom_range(0, 99);
      if (p < 2)
        step(1, 0, 0, $urandom_range(0, 1), $urandom);
      else if (p < 8)
        step(0, 1, $urandom_range(0, 2 * MAX_N - 1),
             $urandom_range(0, 1), $urandom);
      else if (p < 18)
        step(0, 1, $urandom_range(1, MAX_N), 0, 0);
      else
        step(0, 0, 0, $urandom_range(0, 3) != 0, $urandom);
    end

    idle(3);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
